// File: rtl/vend_pkg.sv
// Shared types, constants and the price helper for the vending machine sequencer.
// Money is counted in nickels throughout.
package vend_pkg;

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        MONEY     = 3'd1,
        PURCHASED = 3'd2,
        REJECTION = 3'd3,
        REFUND    = 3'd4
    } state_t;

    localparam int NICKELS_PER_QUARTER = 5;

    // Each price tier is a whole number of quarters.
    function automatic logic [4:0] price_of(input logic [1:0] cost);
        return 5'((int'(cost) + 1) * NICKELS_PER_QUARTER);
    endfunction

endpackage

// File: rtl/vend_price_lookup.sv
// Combinational item code to price tier and price (in nickels).
module vend_price_lookup
    import vend_pkg::*;
(
    input  logic [3:0] button,
    output logic [1:0] cost,
    output logic [4:0] price
);

    always_comb begin
        cost = 2'd0;
        case (button)
            4'hF, 4'hB, 4'h7: cost = 2'd3;
            4'hE, 4'hA, 4'h6: cost = 2'd2;
            4'hD, 4'h9, 4'h5: cost = 2'd1;
            default:          cost = 2'd0;
        endcase
    end

    assign price = price_of(cost);

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine sequencer: coin credit, selection, vend/reject/refund FSM.
// Optional REFUND_DIME_EN: refund pays out dimes while two or more nickels remain.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int MAX_BAL       = 40,
    parameter int REJECT_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nickel,
    input  logic       dime,
    input  logic       sel_valid,
    input  logic [3:0] button,
    input  logic       cancel,
    output logic [5:0] balance,
    output logic [2:0] state,
    output logic       vend,
    output logic [3:0] vend_item,
    output logic       reject,
    output logic       coin_return,
    output logic       change_nickel,
    output logic       change_dime
);

    localparam int CW = (REJECT_CYCLES > 1) ? $clog2(REJECT_CYCLES) : 1;

    state_t          st;
    logic [CW-1:0]   cnt;
    logic [1:0]      unused_cost;
    logic [4:0]      price;
    logic [1:0]      inc;
    logic [6:0]      sum;
    logic            accepting;
    logic            fits;
    logic            credit;
    logic            coin_rej;
    logic [5:0]      bal_c;

    vend_price_lookup u_price (
        .button (button),
        .cost   (unused_cost),
        .price  (price)
    );

    // dime is worth two nickels, so the pair forms the increment directly
    assign inc       = {dime, nickel};
    assign sum       = {1'b0, balance} + {5'd0, inc};
    assign accepting = (st == INIT) || (st == MONEY) || (st == REJECTION);
    assign fits      = sum <= 7'(MAX_BAL);
    assign credit    = accepting && (inc != 2'd0) && fits;
    assign coin_rej  = (inc != 2'd0) && !(accepting && fits);
    assign bal_c     = credit ? sum[5:0] : balance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= INIT;
            balance     <= '0;
            vend_item   <= '0;
            cnt         <= '0;
            coin_return <= 1'b0;
        end else begin
            coin_return <= coin_rej;
            unique case (st)
                INIT: begin
                    balance <= bal_c;
                    if (credit) st <= MONEY;
                end
                MONEY: begin
                    balance <= bal_c;
                    if (cancel) begin
                        st <= (bal_c != 6'd0) ? REFUND : INIT;
                    end else if (sel_valid) begin
                        if (balance >= {1'b0, price}) begin
                            st        <= PURCHASED;
                            vend_item <= button;
                            balance   <= bal_c - {1'b0, price};
                        end else begin
                            st  <= REJECTION;
                            cnt <= CW'(REJECT_CYCLES - 1);
                        end
                    end
                end
                PURCHASED: begin
                    st <= (balance != 6'd0) ? REFUND : INIT;
                end
                REJECTION: begin
                    balance <= bal_c;
                    if (cancel) begin
                        st <= (bal_c != 6'd0) ? REFUND : INIT;
                    end else if (cnt == '0) begin
                        st <= MONEY;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                REFUND: begin
`ifdef REFUND_DIME_EN
                    if (balance >= 6'd2) begin
                        balance <= balance - 6'd2;
                        if (balance == 6'd2) st <= INIT;
                    end else begin
                        balance <= balance - 6'd1;
                        st      <= INIT;
                    end
`else
                    balance <= balance - 6'd1;
                    if (balance == 6'd1) st <= INIT;
`endif
                end
                default: st <= INIT;
            endcase
        end
    end

    assign state  = st;
    assign vend   = (st == PURCHASED);
    assign reject = (st == REJECTION);
`ifdef REFUND_DIME_EN
    assign change_dime   = (st == REFUND) && (balance >= 6'd2);
    assign change_nickel = (st == REFUND) && (balance == 6'd1);
`else
    assign change_dime   = 1'b0;
    assign change_nickel = (st == REFUND);
`endif

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl (default build, nickel-only refund).
module tb_vend_ctrl;

    logic       clk;
    logic       rst;
    logic       nickel;
    logic       dime;
    logic       sel_valid;
    logic [3:0] button;
    logic       cancel;
    logic [5:0] balance;
    logic [2:0] state;
    logic       vend;
    logic [3:0] vend_item;
    logic       reject;
    logic       coin_return;
    logic       change_nickel;
    logic       change_dime;

    int total = 0;
    int bad   = 0;

    vend_ctrl #(.MAX_BAL(40), .REJECT_CYCLES(100)) dut (
        .clk           (clk),
        .rst           (rst),
        .nickel        (nickel),
        .dime          (dime),
        .sel_valid     (sel_valid),
        .button        (button),
        .cancel        (cancel),
        .balance       (balance),
        .state         (state),
        .vend          (vend),
        .vend_item     (vend_item),
        .reject        (reject),
        .coin_return   (coin_return),
        .change_nickel (change_nickel),
        .change_dime   (change_dime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic n, input logic d, input logic s,
                         input logic [3:0] b, input logic c);
        nickel    = n;
        dime      = d;
        sel_valid = s;
        button    = b;
        cancel    = c;
        step();
        nickel    = 1'b0;
        dime      = 1'b0;
        sel_valid = 1'b0;
        cancel    = 1'b0;
    endtask

    task automatic deposit(input int nd, input int nn);
        for (int i = 0; i < nd; i++) pulse(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < nn; i++) pulse(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic drain(input string tag, input int exp);
        int n;
        int g;
        n = 0;
        g = 0;
        pulse(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        while (state == 3'd4 && g < 200) begin
            n += int'(change_nickel);
            step();
            g++;
        end
        check({tag, "_pulses"}, n, exp);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_bal"}, int'(balance), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int g;
        rst = 1'b1;
        nickel = 1'b0;
        dime = 1'b0;
        sel_valid = 1'b0;
        button = 4'h0;
        cancel = 1'b0;
        #22;
        check("rst_state", int'(state), 0);
        check("rst_bal", int'(balance), 0);
        check("rst_outs", int'({vend, reject, coin_return, change_nickel, change_dime}), 0);
        check("rst_item", int'(vend_item), 0);
        step();
        rst = 1'b0;
        step();

        // exact payment, no change
        deposit(10, 0);
        check("t1_bal", int'(balance), 20);
        check("t1_money", int'(state), 1);
        pulse(1'b0, 1'b0, 1'b1, 4'hF, 1'b0);
        check("t1_vend", int'(vend), 1);
        check("t1_item", int'(vend_item), 15);
        check("t1_bal0", int'(balance), 0);
        check("t1_chg", int'(change_nickel), 0);
        step();
        check("t1_vend_off", int'(vend), 0);
        check("t1_init", int'(state), 0);
        check("t1_chg2", int'(change_nickel), 0);

        // overpay by one nickel
        deposit(5, 1);
        check("t2_bal", int'(balance), 11);
        pulse(1'b0, 1'b0, 1'b1, 4'h5, 1'b0);
        check("t2_vend", int'(vend), 1);
        check("t2_item", int'(vend_item), 5);
        check("t2_bal1", int'(balance), 1);
        step();
        check("t2_refund", int'(state), 4);
        check("t2_chg", int'(change_nickel), 1);
        step();
        check("t2_init", int'(state), 0);
        check("t2_chg_off", int'(change_nickel), 0);
        check("t2_bal0", int'(balance), 0);

        // insufficient funds
        deposit(0, 4);
        pulse(1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
        check("t3_rejstate", int'(state), 3);
        n = 0;
        g = 0;
        while (reject && g < 300) begin
            n++;
            step();
            g++;
        end
        check("t3_rejlen", n, 100);
        check("t3_bal", int'(balance), 4);
        check("t3_money", int'(state), 1);
        pulse(1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        check("t3_credit", int'(balance), 5);
        check("t3_still_rej", int'(reject), 1);
        drain("t3_drain", 5);

        // balance cap
        deposit(20, 0);
        check("t4_bal40", int'(balance), 40);
        pulse(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        check("t4_cr", int'(coin_return), 1);
        check("t4_bal_keep", int'(balance), 40);
        step();
        check("t4_cr_off", int'(coin_return), 0);
        drain("t4_drain40", 40);
        deposit(19, 1);
        check("t4_bal39", int'(balance), 39);
        pulse(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        check("t4_cr2", int'(coin_return), 1);
        check("t4_bal39_keep", int'(balance), 39);
        drain("t4_drain39", 39);

        // cancel beats selection, coin during refund is returned
        deposit(3, 1);
        check("t5_bal", int'(balance), 7);
        pulse(1'b0, 1'b0, 1'b1, 4'hF, 1'b1);
        check("t5_refund", int'(state), 4);
        n = int'(change_nickel);
        pulse(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        check("t5_cr", int'(coin_return), 1);
        g = 0;
        while (state == 3'd4 && g < 100) begin
            n += int'(change_nickel);
            step();
            g++;
        end
        check("t5_pulses", n, 7);
        check("t5_init", int'(state), 0);
        check("t5_bal0", int'(balance), 0);

        // reset mid-refund
        deposit(0, 5);
        pulse(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        check("t6_refund", int'(state), 4);
        check("t6_bal", int'(balance), 5);
        #2;
        rst = 1'b1;
        #1;
        check("t6_state", int'(state), 0);
        check("t6_bal0", int'(balance), 0);
        check("t6_outs", int'({vend, reject, coin_return, change_nickel, change_dime}), 0);
        step();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            n += int'(change_nickel);
            step();
        end
        check("t6_no_pulses", n, 0);
        check("t6_idle", int'(state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
